// File: rtl/fig_sweep_driver_pkg.sv
// Shared types and constants for the fig4_12 sweep driver.
package fig_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sweep_state_t;

   // Bit i is F for input code i; fig4_12: F = XZ + Y'Z + X'YZ'.
   localparam logic [7:0] FIG4_12_TT     = 8'hA6;
   localparam int         SETTLE_DEFAULT = 2;
   localparam int         SETTLE_W       = 4;

endpackage

// File: rtl/fig_sweep_driver_settle_counter.sv
// Loadable down-counter that times the settle window of each input code.
module settle_counter
   import fig_sweep_pkg::*;
#(
   parameter int W = SETTLE_W
) (
   input  logic         clock,
   input  logic         reset_L,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/fig_sweep_driver.sv
// Clocked sweep engine: drives every input code into the fig4_12 network,
// waits a settle window, samples F and accumulates mismatches.
module fig_sweep_driver
   import fig_sweep_pkg::*;
#(
   parameter int                  N_IN   = 3,
   parameter int                  SETTLE = SETTLE_DEFAULT,
   parameter logic [2**N_IN-1:0]  EXPECT = FIG4_12_TT
) (
   input  logic                             clock,
   input  logic                             reset_L,
   input  logic                             start,
   input  logic                             F,
   output logic [N_IN-1:0]                  vec,
   output logic                             busy,
   output logic                             done,
   output logic                             pass,
   output logic [2**N_IN-1:0]               mismatch_mask,
   output logic [$clog2(2**N_IN+1)-1:0]     err_count
);

   localparam int                  N_CODES     = 2**N_IN;
   localparam int                  ERR_W       = $clog2(N_CODES + 1);
   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

   sweep_state_t          state_q, state_d;
   logic [N_IN-1:0]       idx_q, idx_d;
   logic [N_CODES-1:0]    mask_q, mask_d;
   logic [ERR_W-1:0]      err_q, err_d;
   logic                  cnt_load;
   logic                  cnt_zero;

   settle_counter #(
      .W (SETTLE_W)
   ) u_settle (
      .clock    (clock),
      .reset_L  (reset_L),
      .load     (cnt_load),
      .load_val (SETTLE_LOAD),
      .en       (state_q == WAIT),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      mask_d   = mask_q;
      err_d    = err_q;
      cnt_load = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               idx_d    = '0;
               mask_d   = '0;
               err_d    = '0;
               cnt_load = 1'b1;
               state_d  = WAIT;
            end
         end
         WAIT: begin
            if (cnt_zero) begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            if (F != EXPECT[idx_q]) begin
               mask_d[idx_q] = 1'b1;
               err_d         = err_q + ERR_W'(1);
            end
            // Terminal test precedes the increment, so idx never wraps.
            if (&idx_q) begin
               state_d = DONE;
            end else begin
               idx_d    = idx_q + N_IN'(1);
               cnt_load = 1'b1;
               state_d  = WAIT;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_L) begin
         state_q <= IDLE;
         idx_q   <= '0;
         mask_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
      end
   end

   // vec tracks idx exactly: both change only on start and SAMPLE->WAIT.
   assign vec           = idx_q;
   assign busy          = (state_q == WAIT) || (state_q == SAMPLE);
   assign done          = (state_q == DONE);
   assign pass          = done && (err_q == '0);
   assign mismatch_mask = mask_q;
   assign err_count     = err_q;

endmodule

// File: tb/tb_fig_sweep_driver.sv
// Directed bench for fig_sweep_driver: two instances (settle 2 and settle 1)
// fed by a fig4_12 model, stuck-at sources and delayed copies of the model.
module tb_fig_sweep_driver;

   localparam int GOLD = 0;
   localparam int TIE0 = 1;
   localparam int TIE1 = 2;
   localparam int DEL1 = 3;
   localparam int DEL2 = 4;

   logic       clock = 1'b0;
   logic       reset_L;
   logic       start0, start1;
   logic       f0, f1;
   logic [2:0] vec0, vec1;
   logic       busy0, busy1, done0, done1, pass0, pass1;
   logic [7:0] mask0, mask1;
   logic [3:0] err0, err1;
   logic       d1_q, d2_q;
   int         mode0, mode1;
   int         npass = 0;
   int         ntotal = 0;

   always #5 clock = ~clock;

   function automatic logic fig(input logic [2:0] v);
      return (v[2] & v[0]) | (~v[1] & v[0]) | (~v[2] & v[1] & ~v[0]);
   endfunction

   always @(posedge clock) begin
      d1_q <= fig(vec1);
      d2_q <= d1_q;
   end

   always_comb begin
      case (mode0)
         TIE0:    f0 = 1'b0;
         TIE1:    f0 = 1'b1;
         default: f0 = fig(vec0);
      endcase
   end

   always_comb begin
      case (mode1)
         TIE0:    f1 = 1'b0;
         TIE1:    f1 = 1'b1;
         DEL1:    f1 = d1_q;
         DEL2:    f1 = d2_q;
         default: f1 = fig(vec1);
      endcase
   end

   fig_sweep_driver #(.N_IN(3), .SETTLE(2), .EXPECT(8'hA6)) u_dut0 (
      .clock         (clock),
      .reset_L       (reset_L),
      .start         (start0),
      .F             (f0),
      .vec           (vec0),
      .busy          (busy0),
      .done          (done0),
      .pass          (pass0),
      .mismatch_mask (mask0),
      .err_count     (err0)
   );

   fig_sweep_driver #(.N_IN(3), .SETTLE(1), .EXPECT(8'hA6)) u_dut1 (
      .clock         (clock),
      .reset_L       (reset_L),
      .start         (start1),
      .F             (f1),
      .vec           (vec1),
      .busy          (busy1),
      .done          (done1),
      .pass          (pass1),
      .mismatch_mask (mask1),
      .err_count     (err1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Pulse start, then follow the sweep cycle by cycle until done.
   task automatic sweep(input bit which, input int per_code, input int exp_len,
                        input int poke_at);
      int j;
      bit got;
      @(negedge clock);
      if (which) start1 = 1'b1; else start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      start1 = 1'b0;
      j   = 0;
      got = 1'b0;
      while (!got && (j <= exp_len + 8)) begin
         if ((which ? done1 : done0) === 1'b1) begin
            got = 1'b1;
         end else begin
            chk("sweep_vec", 32'(which ? vec1 : vec0), 32'(j / per_code));
            chk("sweep_busy", 32'(which ? busy1 : busy0), 32'd1);
            if (j == poke_at) begin
               if (which) start1 = 1'b1; else start0 = 1'b1;
            end else begin
               start0 = 1'b0;
               start1 = 1'b0;
            end
            j++;
            @(negedge clock);
         end
      end
      start0 = 1'b0;
      start1 = 1'b0;
      chk("sweep_len", 32'(j), 32'(exp_len));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1);
   end

   initial begin
      reset_L = 1'b0;
      start0  = 1'b0;
      start1  = 1'b0;
      mode0   = GOLD;
      mode1   = GOLD;
      repeat (2) @(negedge clock);
      chk("rst_vec", 32'(vec0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_pass", 32'(pass0), 32'd0);
      chk("rst_mask", 32'(mask0), 32'h00);
      chk("rst_err", 32'(err0), 32'd0);
      chk("rst_vec1", 32'(vec1), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      reset_L = 1'b1;

      @(negedge clock);
      reset_L = 1'b0;
      start0  = 1'b1;
      @(negedge clock);
      chk("rst_vs_start_busy", 32'(busy0), 32'd0);
      reset_L = 1'b1;
      start0  = 1'b0;
      @(negedge clock);
      chk("idle_no_start_busy", 32'(busy0), 32'd0);

      mode0 = GOLD;
      sweep(1'b0, 3, 24, 7);
      chk("gold_done", 32'(done0), 32'd1);
      chk("gold_pass", 32'(pass0), 32'd1);
      chk("gold_mask", 32'(mask0), 32'h00);
      chk("gold_err", 32'(err0), 32'd0);
      chk("gold_busy", 32'(busy0), 32'd0);

      mode0 = TIE1;
      sweep(1'b0, 3, 24, -1);
      chk("tie1_mask", 32'(mask0), 32'h59);
      chk("tie1_err", 32'(err0), 32'd4);
      chk("tie1_pass", 32'(pass0), 32'd0);

      mode0 = TIE0;
      sweep(1'b0, 3, 24, -1);
      chk("tie0_mask", 32'(mask0), 32'hA6);
      chk("tie0_err", 32'(err0), 32'd4);
      chk("tie0_pass", 32'(pass0), 32'd0);
      chk("tie0_done", 32'(done0), 32'd1);

      @(negedge clock);
      start0 = 1'b1;
      @(negedge clock);
      start0 = 1'b0;
      repeat (15) @(negedge clock);
      chk("mid_vec", 32'(vec0), 32'd5);
      chk("mid_busy", 32'(busy0), 32'd1);
      chk("mid_mask", 32'(mask0), 32'h06);
      chk("mid_err", 32'(err0), 32'd2);
      reset_L = 1'b0;
      @(negedge clock);
      chk("midrst_vec", 32'(vec0), 32'd0);
      chk("midrst_busy", 32'(busy0), 32'd0);
      chk("midrst_done", 32'(done0), 32'd0);
      chk("midrst_mask", 32'(mask0), 32'h00);
      chk("midrst_err", 32'(err0), 32'd0);
      reset_L = 1'b1;
      mode0 = GOLD;
      sweep(1'b0, 3, 24, -1);
      chk("after_rst_pass", 32'(pass0), 32'd1);
      chk("after_rst_mask", 32'(mask0), 32'h00);

      mode1 = DEL1;
      sweep(1'b1, 2, 16, -1);
      chk("del1_done", 32'(done1), 32'd1);
      chk("del1_pass", 32'(pass1), 32'd1);
      chk("del1_mask", 32'(mask1), 32'h00);
      chk("del1_err", 32'(err1), 32'd0);

      @(negedge clock);
      reset_L = 1'b0;
      repeat (2) @(negedge clock);
      reset_L = 1'b1;
      repeat (2) @(negedge clock);
      mode1 = DEL2;
      sweep(1'b1, 2, 16, -1);
      chk("del2_mask", 32'(mask1), 32'hEA);
      chk("del2_err", 32'(err1), 32'd5);
      chk("del2_pass", 32'(pass1), 32'd0);

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule

// File: doc/fig_sweep_driver.md
Name: fig_sweep_driver

Overview:
- Synchronous stimulus/checker stage that sits directly upstream of the fig4_12 combinational gate network.
- It replaces the hand-written initial-block testbench with a clocked engine:
  - steps {X,Y,Z} through all 2^N_IN input codes;
  - holds each code for a programmable settle window covering gate delays;
  - samples F and compares it against an expected truth table.
- Results are reported as a mismatch mask, an error count and a pass flag.

Parameters:
- N_IN, 3, number of driven inputs; vec[2]=X, vec[1]=Y, vec[0]=Z for default.
- SETTLE, 2, cycles each code is held before F is sampled; legal range 1..15.
- EXPECT, 8'hA6, expected F per code, bit i = F for code i (fig4_12: F = XZ + Y'Z + X'YZ').

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset_L  input  1  synchronous, active-low reset.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- F  input  1  DUT output under check.
- vec  output  N_IN  drive to DUT inputs {X,Y,Z}.
- busy  output  1  high in WAIT and SAMPLE.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff err_count==0.
- mismatch_mask  output  2^N_IN  bit i set if F mismatched EXPECT[i].
- err_count  output  $clog2(2^N_IN+1)  number of mismatching codes.

Behaviour:
- Reset (reset_L==0 at a rising edge), taking priority over everything, including mid-sweep:
  - state=IDLE, vec=0, idx=0, cnt=0;
  - mismatch_mask=0, err_count=0;
  - busy=0, done=0, pass=0.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE:
  - start=1 -> idx<=0, vec<=0, cnt<=SETTLE-1, mismatch_mask<=0, err_count<=0, go to WAIT.
- WAIT:
  - cnt!=0 -> cnt<=cnt-1, stay in WAIT;
  - cnt==0 -> go to SAMPLE.
  - vec is held constant throughout.
- SAMPLE (exactly one cycle):
  - if F!=EXPECT[idx]: mismatch_mask[idx]<=1 and err_count<=err_count+1.
  - if idx==2^N_IN-1 -> go to DONE.
  - otherwise idx<=idx+1, vec<=idx+1, cnt<=SETTLE-1, go to WAIT.
- DONE:
  - done=1, pass=(err_count==0); results held.
  - start=1 -> same actions as IDLE start (results cleared, new sweep).
- Timing:
  - Each code occupies SETTLE cycles in WAIT plus 1 cycle in SAMPLE.
  - If start is accepted at edge k, DONE is entered at edge k+2^N_IN*(SETTLE+1); default k+24.
- Signal rules:
  - vec changes only on the start edge and on SAMPLE->WAIT edges, never while F is being sampled.
  - start is ignored while busy.
  - F is sampled with no synchronizer; the DUT path is combinational from registered vec, and SETTLE must cover its settle time.
- Width and wrap rules:
  - idx is N_IN bits and never wraps, because the terminal test precedes the increment.
  - err_count cannot overflow by construction.
- Simultaneous events:
  - reset_L==0 together with start=1 -> reset wins.
  - start held high through DONE -> one restart per DONE entry; the sweep then runs normally.

Decomposition:
- Package fig_sweep_pkg:
  - state enum sweep_state_t {IDLE, WAIT, SAMPLE, DONE};
  - constant FIG4_12_TT = 8'hA6;
  - constant SETTLE_DEFAULT = 2.
- Sub-module settle_counter:
  - loadable down-counter with inputs load, load_val, en and output zero;
  - instantiated once for the WAIT timer.

Test Plan:
- Reset then idle: hold reset_L=0 for 2 cycles, start=0 -> vec=000, busy=0, done=0, mismatch_mask=00, err_count=0.
- Golden sweep: connect fig4_12 model, SETTLE=2, pulse start -> vec steps 0..7, each code held 3 cycles; done asserts 24 edges after start; pass=1, mask=8'h00.
- Faulty DUT: tie F=0 -> mask=8'hA6, err_count=4, pass=0. Tie F=1 -> mask=8'h59, err_count=4.
- Reset mid-sweep: assert reset_L=0 while vec=3'b101 in WAIT -> next edge gives state IDLE, vec=000, mask=0, busy=0. A later start performs a full clean sweep.
- Start while busy and restart: pulse start when vec=010 -> sweep unaffected, still 24 cycles. In DONE, a start with a faulty F (F=0) clears the prior mask, runs a new sweep and reports mask=8'hA6.
- Settle window: SETTLE=1 -> 16-cycle sweep. Model DUT delay as 1 cycle on the golden model -> pass=1. Model 2-cycle delay -> mismatches reported, pass=0.
